frame_capture_rx: RTL and testbench

- Receive end of the binary test-frame stream produced by the frame timing generator: vsync, hsync, valid, 1-bit pixel data and vdone.
- Rebuilds each H_ACTIVE x V_ACTIVE binary frame into a ping-pong row buffer of two banks.
- Checks line and frame geometry, and hands completed frames to the downstream layer through a valid/ack plus row-read interface.
- Drives the generator's start request (test_en) whenever a bank is free.

---
 rtl/frame_pkg.sv | 9 +
 rtl/frame_bank_ram.sv | 30 +++
 rtl/frame_capture_rx.sv | 137 +++++++++++++
 tb/tb_frame_capture_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared geometry, FSM states and row word type for the frame capture receiver
package frame_pkg;
  localparam int H_ACTIVE = 28;
  localparam int V_ACTIVE = 28;
  localparam int ROW_AW = 5;
  localparam int COL_W = $clog2(H_ACTIVE + 2);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DROP} state_t;
  typedef logic [H_ACTIVE-1:0] row_t;
endpackage

// File: rtl/frame_bank_ram.sv
// frame_bank_ram: two banks of V_ACTIVE row words, synchronous write, registered read
module frame_bank_ram
  import frame_pkg::*;
(
  input  logic              i_sclk,
  input  logic              i_rstn,
  input  logic              we,
  input  logic              wbank,
  input  logic [ROW_AW-1:0] waddr,
  input  row_t              wdata,
  input  logic              re,
  input  logic              rbank,
  input  logic [ROW_AW-1:0] raddr,
  output row_t              rdata,
  output logic              rvld
);
  localparam logic [ROW_AW-1:0] ROW_END = ROW_AW'(V_ACTIVE);
  row_t mem [2][V_ACTIVE];
  always_ff @(posedge i_sclk)
    if (we) mem[wbank][waddr] <= wdata;
  // rows beyond the frame read as zero rather than whatever the array holds
  always_ff @(posedge i_sclk)
    if (!i_rstn) begin
      rdata <= '0;
      rvld  <= 1'b0;
    end else begin
      rvld <= re;
      if (re) rdata <= (raddr < ROW_END) ? mem[rbank][raddr] : '0;
    end
endmodule

// File: rtl/frame_capture_rx.sv
// frame_capture_rx: rebuilds binary test frames into a ping-pong row buffer and hands them downstream
module frame_capture_rx
  import frame_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                i_sclk,
  input  logic                i_rstn,
  input  logic                i_vsync,
  input  logic                i_hsync,
  input  logic                i_valid,
  input  logic                i_tdata,
  input  logic                i_vdone,
  output logic                o_test_en,
  output logic                o_frame_valid,
  input  logic                i_frame_ack,
  input  logic                i_rd_en,
  input  logic [ROW_AW-1:0]   i_rd_row,
  output logic [H_ACTIVE-1:0] o_rd_data,
  output logic                o_rd_vld,
  output logic                o_line_err,
  output logic                o_frame_err,
  output logic                o_ovf,
  output logic [CNT_W-1:0]    o_frame_cnt
);
  localparam logic [ROW_AW:0] ROW_END = (ROW_AW + 1)'(V_ACTIVE);
  localparam logic [ROW_AW:0] ROW_MAX = (ROW_AW + 1)'(V_ACTIVE + 1);
  localparam logic [COL_W-1:0] COL_END = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE + 1);
  state_t state, state_n;
  logic vsync_q, valid_q, wr_bank, rd_bank, err_flag;
  logic [1:0] full;
  logic [ROW_AW:0] row_cnt;
  logic [COL_W-1:0] col_cnt;
  row_t shreg;
  logic vs_rise, free, ack, in_cap, line_end, wr_en, line_bad, rows_ok, commit;
  logic start, test_en_n, ovf_n, frame_err_n;
  logic hsync_unused;
  assign hsync_unused = i_hsync;
  assign vs_rise = i_vsync & ~vsync_q;
  assign free = ~full[wr_bank];
  assign ack = i_frame_ack & full[rd_bank];
  assign o_frame_valid = full[rd_bank];
  assign in_cap = state == CAPTURE;
  assign line_end = in_cap & valid_q & ~i_valid;
  assign wr_en = line_end & (col_cnt == COL_END) & (row_cnt < ROW_END);
  assign line_bad = line_end & ~wr_en;
  assign rows_ok = row_cnt == ROW_END;
  assign commit = in_cap & i_vdone & rows_ok & ~err_flag;
  assign frame_err_n = in_cap & i_vdone & ~rows_ok;
  always_comb begin
    state_n = state;
    test_en_n = 1'b0;
    ovf_n = 1'b0;
    start = 1'b0;
    case (state)
      IDLE: begin
        state_n = vs_rise ? (free ? CAPTURE : DROP) : (free ? ARMED : IDLE);
        ovf_n = vs_rise & ~free;
        start = vs_rise & free;
        test_en_n = ~vs_rise & free;
      end
      ARMED: begin
        state_n = vs_rise ? CAPTURE : ARMED;
        start = vs_rise;
      end
      CAPTURE: state_n = i_vdone ? IDLE : CAPTURE;
      DROP: state_n = i_vdone ? IDLE : DROP;
      default: state_n = IDLE;
    endcase
  end
  // commit and ack always target different banks, so both may land in one cycle
  always_ff @(posedge i_sclk)
    if (!i_rstn) begin
      state <= IDLE;
      vsync_q <= 1'b0;
      valid_q <= 1'b0;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
      shreg <= '0;
      err_flag <= 1'b0;
      o_frame_cnt <= '0;
      o_test_en <= 1'b0;
      o_ovf <= 1'b0;
      o_line_err <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state <= state_n;
      vsync_q <= i_vsync;
      valid_q <= i_valid;
      o_test_en <= test_en_n;
      o_ovf <= ovf_n;
      o_line_err <= line_bad;
      o_frame_err <= frame_err_n;
      if (start) begin
        row_cnt <= '0;
        col_cnt <= '0;
        shreg <= '0;
        err_flag <= 1'b0;
      end else if (in_cap) begin
        if (i_valid) begin
          shreg <= {shreg[H_ACTIVE-2:0], i_tdata};
          col_cnt <= (col_cnt == COL_MAX) ? col_cnt : col_cnt + 1'b1;
        end
        if (line_end) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_MAX) ? row_cnt : row_cnt + 1'b1;
        end
        if (line_bad) err_flag <= 1'b1;
      end
      if (commit) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
      if (ack) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
    end
  frame_bank_ram u_ram (
    .i_sclk (i_sclk),
    .i_rstn (i_rstn),
    .we     (wr_en),
    .wbank  (wr_bank),
    .waddr  (row_cnt[ROW_AW-1:0]),
    .wdata  (shreg),
    .re     (i_rd_en),
    .rbank  (rd_bank),
    .raddr  (i_rd_row),
    .rdata  (o_rd_data),
    .rvld   (o_rd_vld)
  );
endmodule

// File: tb/tb_frame_capture_rx.sv
// tb_frame_capture_rx: random frames against a frame-level bank/queue model of the receiver
module tb_frame_capture_rx;
  import frame_pkg::*;
  logic i_sclk = 1'b0, i_rstn = 1'b0;
  logic i_vsync = 1'b0, i_hsync = 1'b0, i_valid = 1'b0, i_tdata = 1'b0, i_vdone = 1'b0;
  logic i_frame_ack = 1'b0, i_rd_en = 1'b0;
  logic [ROW_AW-1:0] i_rd_row = '0;
  logic o_test_en, o_frame_valid, o_rd_vld, o_line_err, o_frame_err, o_ovf;
  logic [H_ACTIVE-1:0] o_rd_data;
  logic [15:0] o_frame_cnt;
  always #5 i_sclk = ~i_sclk;
  frame_capture_rx #(.CNT_W(16)) dut (
    .i_sclk(i_sclk), .i_rstn(i_rstn), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_valid(i_valid), .i_tdata(i_tdata), .i_vdone(i_vdone), .o_test_en(o_test_en),
    .o_frame_valid(o_frame_valid), .i_frame_ack(i_frame_ack), .i_rd_en(i_rd_en),
    .i_rd_row(i_rd_row), .o_rd_data(o_rd_data), .o_rd_vld(o_rd_vld),
    .o_line_err(o_line_err), .o_frame_err(o_frame_err), .o_ovf(o_ovf),
    .o_frame_cnt(o_frame_cnt)
  );
  int n_vec = 0, n_err = 0;
  row_t exp_mem [2][V_ACTIVE];
  row_t cur [V_ACTIVE];
  logic [1:0] exp_full = '0;
  logic exp_wr = 1'b0, exp_rd = 1'b0;
  logic [15:0] exp_cnt = '0;
  row_t exp_rd_data = '0;
  int exp_line = 0, exp_ferr = 0, exp_ovf = 0, reads = 0;
  int mon_line = 0, mon_ferr = 0, mon_ovf = 0, mon_rvld = 0;
  bit rst_seen = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge i_sclk) begin
    if (!i_rstn) begin
      if (rst_seen) begin
        chk("rst_flags", {58'd0, o_test_en, o_frame_valid, o_rd_vld, o_line_err, o_frame_err, o_ovf}, 64'd0);
        chk("rst_cnt", {48'd0, o_frame_cnt}, 64'd0);
        chk("rst_rd_data", {36'd0, o_rd_data}, 64'd0);
      end
    end else begin
      chk("frame_valid", {63'd0, o_frame_valid}, {63'd0, exp_full[exp_rd]});
      chk("frame_cnt", {48'd0, o_frame_cnt}, {48'd0, exp_cnt});
      if (o_rd_vld) chk("rd_data", {36'd0, o_rd_data}, {36'd0, exp_rd_data});
      mon_line += int'(o_line_err);
      mon_ferr += int'(o_frame_err);
      mon_ovf += int'(o_ovf);
      mon_rvld += int'(o_rd_vld);
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_sclk);
      #1;
    end
  endtask
  task automatic check_counts();
    chk("line_err_pulses", 64'(mon_line), 64'(exp_line));
    chk("frame_err_pulses", 64'(mon_ferr), 64'(exp_ferr));
    chk("ovf_pulses", 64'(mon_ovf), 64'(exp_ovf));
  endtask
  task automatic model_ack();
    if (exp_full[exp_rd]) begin
      exp_full[exp_rd] = 1'b0;
      exp_rd = ~exp_rd;
    end
  endtask
  task automatic do_reset();
    i_rstn = 1'b0;
    {i_vsync, i_hsync, i_valid, i_vdone, i_frame_ack, i_rd_en} = '0;
    step(1);
    exp_full = '0;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    exp_cnt = '0;
    rst_seen = 1'b1;
    step(3);
    i_rstn = 1'b1;
    rst_seen = 1'b0;
    step(1);
    chk("test_en_first", {63'd0, o_test_en}, 64'd1);
    step(1);
    chk("test_en_once", {63'd0, o_test_en}, 64'd0);
  endtask
  task automatic do_ack();
    i_frame_ack = 1'b1;
    step(1);
    i_frame_ack = 1'b0;
    model_ack();
    step(1);
  endtask
  task automatic read_row(input int r);
    i_rd_en = 1'b1;
    i_rd_row = r[ROW_AW-1:0];
    exp_rd_data = (r < V_ACTIVE) ? exp_mem[exp_rd][r] : '0;
    reads++;
    step(1);
    i_rd_en = 1'b0;
    step(1);
  endtask
  task automatic read_all();
    for (int r = 0; r < V_ACTIVE; r++) read_row(r);
  endtask
  task automatic send_frame(input int nrows, input int short_row, input bit pattern,
                            input bit ack_vdone, input int abort_row);
    bit dropped;
    int le, n;
    logic px;
    dropped = exp_full[exp_wr];
    i_vsync = 1'b1;
    step(2);
    for (int r = 0; r < nrows; r++) begin
      i_hsync = 1'b1;
      step(1);
      i_hsync = 1'b0;
      n = (r == short_row) ? H_ACTIVE - 1 : H_ACTIVE;
      for (int c = 0; c < n; c++) begin
        if (r == abort_row && c == 13) begin
          do_reset();
          return;
        end
        px = pattern ? logic'((r + c) & 1) : logic'($urandom_range(0, 1));
        i_valid = 1'b1;
        i_tdata = px;
        if (r < V_ACTIVE) cur[r] = {cur[r][H_ACTIVE-2:0], px};
        step(1);
      end
      i_valid = 1'b0;
      step(1 + int'($urandom_range(0, 2)));
    end
    i_vsync = 1'b0;
    step(1);
    i_vdone = 1'b1;
    i_frame_ack = ack_vdone;
    step(1);
    i_vdone = 1'b0;
    i_frame_ack = 1'b0;
    if (ack_vdone) model_ack();
    if (dropped) exp_ovf++;
    else begin
      le = ((short_row >= 0 && short_row < nrows) ? 1 : 0) + ((nrows > V_ACTIVE) ? nrows - V_ACTIVE : 0);
      exp_line += le;
      if (nrows != V_ACTIVE) exp_ferr++;
      if (nrows == V_ACTIVE && le == 0) begin
        for (int r = 0; r < V_ACTIVE; r++) exp_mem[exp_wr][r] = cur[r];
        exp_full[exp_wr] = 1'b1;
        exp_wr = ~exp_wr;
        exp_cnt++;
      end
    end
    step(2);
    check_counts();
  endtask
  initial begin
    int sr;
    do_reset();
    chk("cnt_after_reset", {48'd0, o_frame_cnt}, 64'd0);
    send_frame(V_ACTIVE, -1, 1'b1, 1'b0, -1);
    chk("cnt_first", {48'd0, o_frame_cnt}, 64'd1);
    chk("fv_first", {63'd0, o_frame_valid}, 64'd1);
    read_row(0);
    chk("row0_literal", {36'd0, o_rd_data}, {36'd0, 28'h5555555});
    read_row(1);
    chk("row1_literal", {36'd0, o_rd_data}, {36'd0, 28'hAAAAAAA});
    read_row(30);
    chk("row_out_of_range", {36'd0, o_rd_data}, 64'd0);
    read_all();
    do_ack();
    chk("fv_after_ack", {63'd0, o_frame_valid}, 64'd0);
    send_frame(V_ACTIVE, -1, 1'b0, 1'b0, -1);
    send_frame(V_ACTIVE, -1, 1'b0, 1'b0, -1);
    chk("cnt_two_more", {48'd0, o_frame_cnt}, 64'd3);
    send_frame(V_ACTIVE, -1, 1'b0, 1'b0, -1);
    chk("cnt_after_drop", {48'd0, o_frame_cnt}, 64'd3);
    chk("ovf_once", 64'(mon_ovf), 64'd1);
    do_ack();
    read_all();
    send_frame(V_ACTIVE, 5, 1'b0, 1'b0, -1);
    chk("short_line_err", 64'(mon_line), 64'd1);
    chk("short_no_frame_err", 64'(mon_ferr), 64'd0);
    chk("short_no_commit", {48'd0, o_frame_cnt}, 64'd3);
    send_frame(V_ACTIVE - 1, -1, 1'b0, 1'b0, -1);
    chk("few_rows_frame_err", 64'(mon_ferr), 64'd1);
    send_frame(V_ACTIVE + 1, -1, 1'b0, 1'b0, -1);
    chk("extra_row_line_err", 64'(mon_line), 64'd2);
    chk("extra_row_frame_err", 64'(mon_ferr), 64'd2);
    send_frame(V_ACTIVE, -1, 1'b0, 1'b1, -1);
    chk("cnt_commit_ack", {48'd0, o_frame_cnt}, 64'd4);
    chk("fv_commit_ack", {63'd0, o_frame_valid}, 64'd1);
    read_all();
    send_frame(V_ACTIVE, -1, 1'b0, 1'b0, 10);
    check_counts();
    chk("cnt_mid_reset", {48'd0, o_frame_cnt}, 64'd0);
    send_frame(V_ACTIVE, -1, 1'b0, 1'b0, -1);
    chk("cnt_post_reset", {48'd0, o_frame_cnt}, 64'd1);
    read_all();
    for (int i = 0; i < 4; i++) begin
      sr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V_ACTIVE - 1)) : -1;
      send_frame(V_ACTIVE, sr, 1'b0, 1'($urandom_range(0, 1)), -1);
      if (o_frame_valid) read_all();
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    check_counts();
    chk("rd_vld_count", 64'(mon_rvld), 64'(reads));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
